// File: rtl/port_arb.sv
`default_nettype none
// ============================================================================
// Module      : port_arb
// Description : Round-robin arbiter for one destination port. Grants the port
//               to one requester at a time, rejects every other outstanding
//               request and holds ownership until the owner releases.
// Revision    : 1.0 - initial release
// ============================================================================
module port_arb #(
    parameter int PORTNUM = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [PORTNUM-1:0]         i_req,
    input  logic                       i_release,
    output logic                       o_ready,
    output logic [PORTNUM-1:0]         o_resp,
    output logic [PORTNUM-1:0]         o_nresp,
    output logic [$clog2(PORTNUM)-1:0] o_owner,
    output logic                       o_owner_vld
);

    localparam int               PTR_W  = $clog2(PORTNUM);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(PORTNUM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PORTNUM-1:0] r_ans;
    logic [PORTNUM-1:0] w_ans_nxt;
    logic [PORTNUM-1:0] w_elig;
    logic [PORTNUM-1:0] w_win_oh;
    logic [PORTNUM-1:0] w_resp_nxt;
    logic [PORTNUM-1:0] w_nresp_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic               w_ready_nxt;
    logic               w_vld_nxt;

    // First eligible requester at or above ptr, wrapping past the top index.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [PORTNUM-1:0] elig,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < PORTNUM; k++) begin
            idx = PTR_W'((int'(ptr) + k) % PORTNUM);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A request is eligible only until it has been answered once.
    assign w_elig    = i_req & ~r_ans;
    assign w_win     = rr_pick(w_elig, r_ptr);
    assign w_win_oh  = {{(PORTNUM-1){1'b0}}, 1'b1} << w_win;
    // Answered bits stick while the request is held and clear once it drops.
    assign w_ans_nxt = (r_ans | w_resp_nxt | w_nresp_nxt) & i_req;

    // Next-state and next-output decode; pulses default to zero every cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = '0;
        w_nresp_nxt = '0;
        w_ready_nxt = o_ready;
        w_vld_nxt   = o_owner_vld;
        w_owner_nxt = o_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_elig != '0) begin
                    w_resp_nxt  = w_win_oh;
                    w_nresp_nxt = w_elig & ~w_win_oh;
                    w_owner_nxt = w_win;
                    w_vld_nxt   = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_ptr_nxt   = (w_win == C_LAST) ? '0 : w_win + 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // Requests seen during the release cycle wait for S_IDLE.
                if (i_release) begin
                    w_ready_nxt = 1'b1;
                    w_vld_nxt   = 1'b0;
                    w_owner_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_nresp_nxt = w_elig;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ans       <= '0;
            r_ptr       <= '0;
            o_ready     <= 1'b1;
            o_resp      <= '0;
            o_nresp     <= '0;
            o_owner     <= '0;
            o_owner_vld <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ans       <= w_ans_nxt;
            r_ptr       <= w_ptr_nxt;
            o_ready     <= w_ready_nxt;
            o_resp      <= w_resp_nxt;
            o_nresp     <= w_nresp_nxt;
            o_owner     <= w_owner_nxt;
            o_owner_vld <= w_vld_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_arb
// Description : Directed scoreboard bench for port_arb (16-port and 5-port).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_arb;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req_a = '0;
    logic        rel_a = 1'b0;
    logic [4:0]  req_b = '0;
    logic        rel_b = 1'b0;

    logic        ready_a;
    logic [15:0] resp_a;
    logic [15:0] nresp_a;
    logic [3:0]  owner_a;
    logic        vld_a;

    logic        ready_b;
    logic [4:0]  resp_b;
    logic [4:0]  nresp_b;
    logic [2:0]  owner_b;
    logic        vld_b;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        bit          sel;
        logic        ready;
        logic        vld;
        logic [3:0]  owner;
        logic [15:0] resp;
        logic [15:0] nresp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    port_arb #(.PORTNUM(16)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req_a),
        .i_release   (rel_a),
        .o_ready     (ready_a),
        .o_resp      (resp_a),
        .o_nresp     (nresp_a),
        .o_owner     (owner_a),
        .o_owner_vld (vld_a)
    );

    port_arb #(.PORTNUM(5)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req_b),
        .i_release   (rel_b),
        .o_ready     (ready_b),
        .o_resp      (resp_b),
        .o_nresp     (nresp_b),
        .o_owner     (owner_b),
        .o_owner_vld (vld_b)
    );

    task automatic push_exp(input bit sel, input logic rdy, input logic vld,
                            input logic [3:0] own, input logic [15:0] rsp,
                            input logic [15:0] nrsp, input string tag);
        exp_t e;
        e.sel = sel; e.ready = rdy; e.vld = vld; e.owner = own;
        e.resp = rsp; e.nresp = nrsp; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [37:0] obs;
        logic [37:0] expv;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed none, expected an entry");
        end else begin
            e = exp_q.pop_front();
            if (!e.sel)
                obs = {ready_a, vld_a, owner_a, resp_a, nresp_a};
            else
                obs = {ready_b, vld_b, 1'b0, owner_b, 11'b0, resp_b, 11'b0, nresp_b};
            expv = {e.ready, e.vld, e.owner, e.resp, e.nresp};
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s: observed rdy=%b vld=%b own=%0d resp=%h nresp=%h, expected rdy=%b vld=%b own=%0d resp=%h nresp=%h",
                       e.tag, obs[37], obs[36], obs[35:32], obs[31:16], obs[15:0],
                       expv[37], expv[36], expv[35:32], expv[31:16], expv[15:0]);
            end
        end
    endtask

    // Drive one cycle of inputs, record what the next edge must produce, check it.
    task automatic step(input bit sel, input logic [15:0] req, input logic rel,
                        input logic rdy, input logic vld, input logic [3:0] own,
                        input logic [15:0] rsp, input logic [15:0] nrsp,
                        input string tag);
        if (sel) begin
            req_a = '0;      rel_a = 1'b0;
            req_b = req[4:0]; rel_b = rel;
        end else begin
            req_a = req;     rel_a = rel;
            req_b = '0;      rel_b = 1'b0;
        end
        push_exp(sel, rdy, vld, own, rsp, nrsp, tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        #12;
        push_exp(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, "reset_a"); check_pop();
        push_exp(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, "reset_b"); check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //        sel   req       rel   rdy   vld   own    resp      nresp
        step(1'b0, 16'h0004, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0004, 16'h0000, "single_grant");
        step(1'b0, 16'h0004, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0000, 16'h0000, "single_held");
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0000, 16'h0000, "single_drop");
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_1");
        step(1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 4'd15, 16'h8000, 16'h0000, "grant_15");
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd15, 16'h0000, 16'h0000, "own_15");
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_2");
        step(1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0001, 16'h8000, "wrap_grant_0");
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h0000, "own_0");
        step(1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h0020, "busy_reject");
        step(1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h0000, "busy_reject_held");
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_3");
        step(1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 4'd15, 16'h8000, 16'h0000, "grant_15_again");
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_4");
        step(1'b0, 16'h0009, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0001, 16'h0008, "simul_grant");
        step(1'b0, 16'h0009, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h0000, "simul_held");
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_5");
        step(1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 4'd1,  16'h0002, 16'h0001, "rr_ptr_1");
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1,  16'h0000, 16'h0000, "own_1");
        step(1'b0, 16'h0008, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "release_same_req");
        step(1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0008, 16'h0000, "grant_after_release");
        step(1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0000, 16'h0000, "own_3_held");

        // Asynchronous reset while requester 3 owns the port and still requests.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, "async_reset"); check_pop();
        @(posedge clk);
        #1;
        push_exp(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0, "reset_held"); check_pop();
        #2;
        rst_n = 1'b1;
        step(1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0008, 16'h0000, "regrant_after_reset");

        // Five-port instance: top index winning wraps the pointer to 0.
        step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0000, "p5_grant_4");
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "p5_release");
        step(1'b1, 16'h0019, 1'b0, 1'b0, 1'b1, 4'd0,  16'h0001, 16'h0018, "p5_wrap_grant_0");
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, "p5_release_2");
        step(1'b1, 16'h0018, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0008, 16'h0010, "p5_rr_grant_3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
